// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding data-memory access with a
// valid/ready style handshake, lane steering and load extension.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  input  logic        flush,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic        idle, busy;
  logic        req_seen, one_dir;
  logic        f3_legal, aligned, ok;
  logic        accept, bad;
  logic        sz_b, sz_h;
  logic [3:0]  be_d;
  logic [31:0] wd_d;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wd_q;
  logic        kill_q;

  logic        done, load_done;
  logic [31:0] lane;
  logic [31:0] load_val;

  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        err_q;

  assign idle = (state_q == IDLE);
  assign busy = (state_q == BUSY);

  assign req_seen = ex_valid & ~flush
                  & (mem_read | mem_write);
  assign one_dir  = mem_read ^ mem_write;

  // Unsigned loads exist only for reads.
  always_comb begin
    f3_legal = 1'b0;
    unique case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = mem_read;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign sz_b = (funct3[1:0] == 2'b00);
  assign sz_h = (funct3[1:0] == 2'b01);

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      sz_b:    aligned = 1'b1;
      sz_h:    aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign ok     = one_dir & f3_legal & aligned;
  assign accept = idle & req_seen & ok;
  assign bad    = idle & req_seen & ~ok;

  always_comb begin
    be_d = 4'b1111;
    wd_d = wdata;
    unique case (1'b1)
      sz_b: begin
        be_d = 4'b0001 << addr[1:0];
        wd_d = {4{wdata[7:0]}};
      end
      sz_h: begin
        be_d = 4'b0011 << addr[1:0];
        wd_d = {2{wdata[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = wdata;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)     state_d = BUSY;
      BUSY: if (dmem_ready) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= bad;
    end
  end

  // Request fields are frozen at accept and held until completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      off_q  <= 2'b00;
      rd_q   <= 5'd0;
      addr_q <= 32'd0;
      be_q   <= 4'b0000;
      wd_q   <= 32'd0;
      kill_q <= 1'b0;
    end else if (accept) begin
      we_q   <= mem_write;
      f3_q   <= funct3;
      off_q  <= addr[1:0];
      rd_q   <= rd;
      addr_q <= {addr[31:2], 2'b00};
      be_q   <= be_d;
      wd_q   <= wd_d;
      kill_q <= 1'b0;
    end else if (busy && flush) begin
      kill_q <= 1'b1;
    end
  end

  assign done      = busy & dmem_ready;
  assign load_done = done & ~we_q & ~kill_q & ~flush;

  assign lane = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_val = lane;
    unique case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
    end else begin
      wb_valid_q <= load_done;
      if (load_done) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= load_val;
      end
    end
  end

  assign dmem_req   = busy;
  assign dmem_we    = busy & we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wd_q;
  assign stall      = accept | busy;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized
// accesses against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        flush, dmem_ready;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rd(rd),
    .flush(flush), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  // observations from run_access
  logic        o_stall_t, o_req1, o_err1, o_err2, o_stall1;
  logic        o_we, o_stable, o_req_post, o_stall_post;
  logic [31:0] o_addr, o_wdata, o_wb_data, o_hold_data;
  logic [3:0]  o_be;
  logic [4:0]  o_wb_rd, o_hold_rd;
  int          o_busy_n, o_stall_n, o_wbv_n, o_wb_first;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_legal(input logic mr, input logic mw,
                                 input logic [2:0] f3,
                                 input logic [31:0] a);
    bit f_ok;
    if (mr == mw) return 0;
    if (mr) f_ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else    f_ok = (f3 == 0 || f3 == 1 || f3 == 2);
    return f_ok && ((int'(a[1:0]) % nbytes(f3)) == 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [31:0] a);
    int unsigned m;
    m = ((32'd1 << nbytes(f3)) - 1) << a[1:0];
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] wd);
    int n;
    n = nbytes(f3);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] rdat);
    longint unsigned v, m;
    int n;
    n = nbytes(f3);
    v = longint'(rdat >> (8 * int'(a[1:0])));
    m = 64'd1 << (8 * n);
    v = v % m;
    if (f3[2] == 1'b0 && n < 4 && v >= m / 2)
      v = v + 64'h1_0000_0000 - m;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; mem_read = 0; mem_write = 0;
    funct3 = 0; addr = 0; wdata = 0; rd = 0;
    flush = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  // Drives one access from a cycle boundary and records what the DUT did.
  task automatic run_access(input logic mr, input logic mw,
                            input logic [2:0] f3,
                            input logic [31:0] a,
                            input logic [31:0] wd,
                            input logic [4:0] r,
                            input logic [31:0] rdat,
                            input int dly, input bit fl_busy);
    ex_valid = 1; mem_read = mr; mem_write = mw;
    funct3 = f3; addr = a; wdata = wd; rd = r;
    flush = 0; dmem_ready = 0;
    #1;
    o_stall_t = stall;
    o_stall_n = int'(stall);
    step();
    ex_valid = 0; mem_read = 0; mem_write = 0;
    funct3 = 3'($urandom); addr = $urandom;
    wdata = $urandom; rd = 5'($urandom);
    #1;
    o_req1 = dmem_req; o_err1 = err; o_stall1 = stall;
    o_we = dmem_we; o_addr = dmem_addr;
    o_be = dmem_be; o_wdata = dmem_wdata;
    o_busy_n = 0; o_stable = 1; o_wbv_n = 0; o_wb_first = -1;
    o_err2 = 0; o_req_post = 0; o_stall_post = 0;
    if (!dmem_req) begin
      step();
      #1 o_err2 = err;
      step();
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      if (k > 0) #1;
      if (dmem_req) o_busy_n++;
      o_stall_n += int'(stall);
      if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
          {o_we, o_addr, o_be, o_wdata}) o_stable = 0;
      dmem_ready = (k == dly);
      dmem_rdata = (k == dly) ? rdat : $urandom;
      flush = fl_busy && (k == 0);
      step();
    end
    dmem_ready = 0; flush = 0; dmem_rdata = $urandom;
    #1;
    o_req_post = dmem_req;
    o_stall_post = stall;
    for (int p = 0; p < 3; p++) begin
      if (p > 0) #1;
      if (wb_valid) begin
        o_wbv_n++;
        if (o_wb_first < 0) begin
          o_wb_first = p; o_wb_data = wb_data; o_wb_rd = wb_rd;
        end
      end
      o_hold_data = wb_data; o_hold_rd = wb_rd;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1;
    idle_inputs();
    #1 rst_n = 0;
    step(); step();
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_be, stall, wb_valid, err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0",
               {dmem_req, dmem_we, dmem_be, stall, wb_valid, err});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_data, wb_rd} !== 101'd0) begin
      errors++;
      $display("FAIL reset_data addr=%h wd=%h wb=%h rd=%0d want 0",
               dmem_addr, dmem_wdata, wb_data, wb_rd);
    end
    step();
    rst_n = 1;
    run_access(1, 0, 3'b010, 32'h0000_0010, 0, 5'd1,
               32'h0BAD_F00D, 0, 0);
    checks++;
    if (o_stall_t !== 1 || o_req1 !== 1) begin
      errors++;
      $display("FAIL first_accept stall=%b req=%b want 1 1",
               o_stall_t, o_req1);
    end
  endtask

  task automatic test_lb();
    run_access(1, 0, 3'b000, 32'h0000_1003, $urandom, 5'd7,
               32'h80FF_FF00, 0, 0);
    checks++;
    if (o_addr !== 32'h1000 || o_be !== 4'b1000 || o_we !== 0) begin
      errors++;
      $display("FAIL lb_req addr=%h be=%b we=%b want 1000 1000 0",
               o_addr, o_be, o_we);
    end
    checks++;
    if (o_wbv_n !== 1 || o_wb_first !== 0) begin
      errors++;
      $display("FAIL lb_wb_pulse n=%0d at=%0d want 1 0",
               o_wbv_n, o_wb_first);
    end
    checks++;
    if (o_wb_data !== 32'hFFFF_FF80 || o_wb_rd !== 5'd7) begin
      errors++;
      $display("FAIL lb_data got=%h rd=%0d want ffffff80 7",
               o_wb_data, o_wb_rd);
    end
    checks++;
    if (o_stall_n !== 2 || o_req_post !== 0 || o_stall_post !== 0) begin
      errors++;
      $display("FAIL lb_timing stalls=%0d req=%b stall=%b want 2 0 0",
               o_stall_n, o_req_post, o_stall_post);
    end
  endtask

  task automatic test_sh();
    run_access(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd3,
               $urandom, 0, 0);
    checks++;
    if (o_we !== 1 || o_be !== 4'b1100 || o_addr !== 32'h2000) begin
      errors++;
      $display("FAIL sh_req we=%b be=%b addr=%h want 1 1100 2000",
               o_we, o_be, o_addr);
    end
    checks++;
    if (o_wdata !== 32'hABCD_ABCD) begin
      errors++;
      $display("FAIL sh_wdata got=%h want abcdabcd", o_wdata);
    end
    checks++;
    if (o_wbv_n !== 0 || o_hold_data !== 32'hFFFF_FF80) begin
      errors++;
      $display("FAIL sh_no_wb n=%0d hold=%h want 0 ffffff80",
               o_wbv_n, o_hold_data);
    end
  endtask

  task automatic test_misaligned();
    run_access(1, 0, 3'b010, 32'h0000_0006, 0, 5'd4, 0, 0, 0);
    checks++;
    if (o_err1 !== 1 || o_err2 !== 0) begin
      errors++;
      $display("FAIL mis_err t1=%b t2=%b want 1 0", o_err1, o_err2);
    end
    checks++;
    if (o_req1 !== 0 || o_stall_t !== 0 || o_stall1 !== 0) begin
      errors++;
      $display("FAIL mis_noreq req=%b stall=%b/%b want 0 0/0",
               o_req1, o_stall_t, o_stall1);
    end
  endtask

  task automatic test_lhu_delay();
    run_access(1, 0, 3'b101, 32'h0000_3002, 0, 5'd12,
               32'hBEEF_0000, 2, 0);
    checks++;
    if (o_stall_n !== 4 || o_busy_n !== 3) begin
      errors++;
      $display("FAIL lhu_stall stalls=%0d busy=%0d want 4 3",
               o_stall_n, o_busy_n);
    end
    checks++;
    if (o_stable !== 1 || o_be !== 4'b1100 || o_addr !== 32'h3000) begin
      errors++;
      $display("FAIL lhu_req stable=%b be=%b addr=%h want 1 1100 3000",
               o_stable, o_be, o_addr);
    end
    checks++;
    if (o_wbv_n !== 1 || o_wb_data !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL lhu_data n=%0d got=%h want 1 0000beef",
               o_wbv_n, o_wb_data);
    end
  endtask

  task automatic test_flush_busy();
    run_access(1, 0, 3'b010, 32'h0000_0040, 0, 5'd5,
               32'h1111_2222, 1, 1);
    checks++;
    if (o_busy_n !== 2 || o_req_post !== 0) begin
      errors++;
      $display("FAIL flush_busy_req busy=%0d post=%b want 2 0",
               o_busy_n, o_req_post);
    end
    checks++;
    if (o_wbv_n !== 0) begin
      errors++;
      $display("FAIL flush_busy_wb n=%0d want 0", o_wbv_n);
    end
  endtask

  task automatic test_ignore();
    ex_valid = 1; mem_read = 0; mem_write = 0;
    funct3 = 3'($urandom); addr = $urandom;
    dmem_ready = 1; dmem_rdata = $urandom;
    #1;
    checks++;
    if (stall !== 0) begin
      errors++;
      $display("FAIL ignore_stall got=%b want 0", stall);
    end
    step();
    #1;
    checks++;
    if ({dmem_req, err, wb_valid} !== 3'b000) begin
      errors++;
      $display("FAIL ignore_out req/err/wbv=%b want 000",
               {dmem_req, err, wb_valid});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_flush_idle();
    ex_valid = 1; mem_read = 1; mem_write = 0;
    funct3 = 3'b010; addr = 32'h10; flush = 1;
    #1;
    checks++;
    if (stall !== 0) begin
      errors++;
      $display("FAIL flush_idle_stall got=%b want 0", stall);
    end
    step();
    addr = 32'h11;
    #1;
    checks++;
    if (dmem_req !== 0 || err !== 0) begin
      errors++;
      $display("FAIL flush_idle_req req=%b err=%b want 0 0",
               dmem_req, err);
    end
    step();
    #1;
    checks++;
    if (err !== 0) begin
      errors++;
      $display("FAIL flush_idle_err got=%b want 0", err);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    ex_valid = 1; mem_read = 1; mem_write = 0;
    funct3 = 3'b010; addr = 32'h100; rd = 5'd9;
    step();
    idle_inputs();
    dmem_ready = 1; dmem_rdata = 32'h1357_9BDF;
    step();
    ex_valid = 1; mem_read = 0; mem_write = 1;
    funct3 = 3'b000; addr = 32'h203; wdata = 32'h0000_005A;
    dmem_ready = 0;
    #1;
    checks++;
    if (wb_valid !== 1 || wb_data !== 32'h1357_9BDF || wb_rd !== 5'd9
        || stall !== 1) begin
      errors++;
      $display("FAIL b2b_first wbv=%b data=%h rd=%0d stall=%b",
               wb_valid, wb_data, wb_rd, stall);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1 || dmem_addr !== 32'h200 || dmem_be !== 4'b1000
        || dmem_we !== 1 || dmem_wdata !== 32'h5A5A_5A5A) begin
      errors++;
      $display("FAIL b2b_second req=%b addr=%h be=%b we=%b wd=%h",
               dmem_req, dmem_addr, dmem_be, dmem_we, dmem_wdata);
    end
    checks++;
    if (wb_valid !== 0) begin
      errors++;
      $display("FAIL b2b_pulse wbv=%b want 0", wb_valid);
    end
    dmem_ready = 1;
    step();
    dmem_ready = 0;
    #1;
    checks++;
    if (dmem_req !== 0) begin
      errors++;
      $display("FAIL b2b_done req=%b want 0", dmem_req);
    end
    step();
  endtask

  task automatic test_reset_busy();
    int wbv;
    ex_valid = 1; mem_read = 1; mem_write = 0;
    funct3 = 3'b010; addr = 32'h80; rd = 5'd17;
    step();
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1) begin
      errors++;
      $display("FAIL rstbusy_pre req=%b want 1", dmem_req);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_be, stall, wb_valid, err} !== 9'd0 ||
        {dmem_addr, dmem_wdata, wb_data, wb_rd} !== 101'd0) begin
      errors++;
      $display("FAIL rstbusy_out req=%b addr=%h be=%b wb=%h want 0",
               dmem_req, dmem_addr, dmem_be, wb_data);
    end
    dmem_ready = 1; dmem_rdata = 32'hFFFF_FFFF;
    step(); step();
    rst_n = 1; dmem_ready = 0;
    wbv = 0;
    for (int i = 0; i < 2; i++) begin
      #1 if (wb_valid || dmem_req) wbv++;
      step();
    end
    checks++;
    if (wbv !== 0) begin
      errors++;
      $display("FAIL rstbusy_discard events=%0d want 0", wbv);
    end
    run_access(0, 1, 3'b010, 32'h44, 32'hCAFE_F00D, 5'd0, 0, 0, 0);
    checks++;
    if (o_we !== 1 || o_be !== 4'b1111 || o_addr !== 32'h44 ||
        o_wdata !== 32'hCAFE_F00D || o_busy_n !== 1 ||
        o_req_post !== 0) begin
      errors++;
      $display("FAIL rstbusy_sw we=%b be=%b addr=%h wd=%h busy=%0d",
               o_we, o_be, o_addr, o_wdata, o_busy_n);
    end
  endtask

  task automatic test_random();
    logic        mr, mw, exp_ok, exp_wb;
    logic [2:0]  f3;
    logic [31:0] a, wd, rdat;
    logic [4:0]  r;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    bit          known;
    int          dly, pick, sel;
    bit          fl;
    last_data = 0; last_rd = 0; known = 1;
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 9);
      mr = (sel <= 5); mw = (sel == 0) || (sel >= 6);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (mw && !mr) f3 = 3'($urandom_range(0, 2));
      else begin
        pick = $urandom_range(0, 4);
        f3 = (pick > 2) ? 3'(pick + 1) : 3'(pick);
      end
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd = $urandom; rdat = $urandom; r = 5'($urandom);
      dly = $urandom_range(0, 3);
      fl = ($urandom_range(0, 7) == 0);
      run_access(mr, mw, f3, a, wd, r, rdat, dly, fl);
      exp_ok = m_legal(mr, mw, f3, a);
      checks++;
      if (o_stall_t !== exp_ok || o_req1 !== exp_ok ||
          o_err1 !== !exp_ok) begin
        errors++;
        $display("FAIL rnd_accept t=%0d stall=%b req=%b err=%b ok=%b",
                 t, o_stall_t, o_req1, o_err1, exp_ok);
      end
      if (!exp_ok) begin
        checks++;
        if (o_err2 !== 0) begin
          errors++;
          $display("FAIL rnd_err_pulse t=%0d got=%b want 0", t, o_err2);
        end
        continue;
      end
      checks++;
      if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(f3, a) ||
          o_we !== mw) begin
        errors++;
        $display("FAIL rnd_req t=%0d addr=%h be=%b we=%b want %h %b %b",
                 t, o_addr, o_be, o_we, {a[31:2], 2'b00},
                 m_be(f3, a), mw);
      end
      if (mw) begin
        checks++;
        if (o_wdata !== m_wdata(f3, wd)) begin
          errors++;
          $display("FAIL rnd_wdata t=%0d got=%h want %h",
                   t, o_wdata, m_wdata(f3, wd));
        end
      end
      checks++;
      if (o_stable !== 1 || o_busy_n !== dly + 1 ||
          o_stall_n !== dly + 2) begin
        errors++;
        $display("FAIL rnd_timing t=%0d stable=%b busy=%0d stalls=%0d",
                 t, o_stable, o_busy_n, o_stall_n);
      end
      exp_wb = mr && !fl;
      checks++;
      if (o_wbv_n !== int'(exp_wb)) begin
        errors++;
        $display("FAIL rnd_wbv t=%0d n=%0d want %0d",
                 t, o_wbv_n, exp_wb);
      end
      if (exp_wb) begin
        checks++;
        if (o_wb_first !== 0 || o_wb_data !== m_load(f3, a, rdat) ||
            o_wb_rd !== r) begin
          errors++;
          $display("FAIL rnd_load t=%0d at=%0d got=%h rd=%0d want %h %0d",
                   t, o_wb_first, o_wb_data, o_wb_rd,
                   m_load(f3, a, rdat), r);
        end
        last_data = m_load(f3, a, rdat); last_rd = r; known = 1;
      end else if (mr) begin
        known = 0;
      end else if (known) begin
        checks++;
        if (o_hold_data !== last_data || o_hold_rd !== last_rd) begin
          errors++;
          $display("FAIL rnd_hold t=%0d got=%h/%0d want %h/%0d",
                   t, o_hold_data, o_hold_rd, last_data, last_rd);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misaligned();
    test_lhu_delay();
    test_flush_busy();
    test_ignore();
    test_flush_idle();
    test_back_to_back();
    test_reset_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
